// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter states, error codes and common command bytes.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        ACK,
        WAIT_IDLE
    } ps2_state_e;

    localparam logic [1:0] ERR_NACK    = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // Largest of three cycle counts; sizes the shared phase/timeout counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake, status pulses and open-drain line controls of the PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       tx_done;
    logic       tx_error;
    logic [1:0] err_code;

    modport master (
        output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error, err_code
    );

    modport slave (
        input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, tx_done, tx_error, err_code
    );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines, plus clock falling-edge detect.
// Shared with the receive side, which needs exactly the same three signals.
module ps2_line_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic clk_o,
    output logic data_o,
    output logic clk_fall_o
);

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    // Resample both lines; flops reset to 1 because idle PS/2 lines float high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_i;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_i;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_o      = clk_sync_q;
    assign data_o     = data_sync_q;
    assign clk_fall_o = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out on device clock falls, ACK check.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned REQ_CYCLES     = 50,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic          clock,
    input logic          reset,
    ps2_host_tx_if.slave bus
);

    localparam int unsigned CNT_MAX = max3(INHIBIT_CYCLES, REQ_CYCLES, TIMEOUT_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    ps2_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       frame_q;
    logic [3:0]       bit_cnt_q;
    logic             tx_ready_q, busy_q, clk_oe_q, data_oe_q;
    logic             done_q, error_q;
    logic [1:0]       err_code_q;

    logic clk_sync, data_sync, clk_fall;
    logic timeout;

    ps2_line_sync u_sync (
        .clk_i      (clock),
        .rst_i      (reset),
        .ps2_clk_i  (bus.ps2_clk_in),
        .ps2_data_i (bus.ps2_data_in),
        .clk_o      (clk_sync),
        .data_o     (data_sync),
        .clk_fall_o (clk_fall)
    );

    // The counter is cleared on SEND entry and keeps running through ACK and WAIT_IDLE.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            frame_q    <= '0;
            bit_cnt_q  <= '0;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            clk_oe_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid && tx_ready_q) begin
                        frame_q    <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        bit_cnt_q  <= '0;
                        cnt_q      <= '0;
                        tx_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        clk_oe_q   <= 1'b1;
                        state_q    <= INHIBIT;
                    end
                end
                INHIBIT: begin
                    if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt_q     <= '0;
                        data_oe_q <= 1'b1;
                        state_q   <= REQ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                REQ: begin
                    if (cnt_q == CNT_W'(REQ_CYCLES - 1)) begin
                        cnt_q    <= '0;
                        clk_oe_q <= 1'b0;
                        state_q  <= SEND;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SEND, ACK, WAIT_IDLE: begin
                    if (timeout) begin
                        error_q    <= 1'b1;
                        err_code_q <= ERR_TIMEOUT;
                        tx_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        clk_oe_q   <= 1'b0;
                        data_oe_q  <= 1'b0;
                        state_q    <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                        if (state_q == SEND) begin
                            // Fall 10 shifts out the stop bit, which releases data for the ACK.
                            if (clk_fall) begin
                                data_oe_q <= ~frame_q[bit_cnt_q];
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                                if (bit_cnt_q == 4'd9) begin
                                    state_q <= ACK;
                                end
                            end
                        end else if (state_q == ACK) begin
                            if (clk_fall) begin
                                if (!data_sync) begin
                                    state_q <= WAIT_IDLE;
                                end else begin
                                    error_q    <= 1'b1;
                                    err_code_q <= ERR_NACK;
                                    tx_ready_q <= 1'b1;
                                    busy_q     <= 1'b0;
                                    state_q    <= IDLE;
                                end
                            end
                        end else if (clk_sync && data_sync) begin
                            done_q     <= 1'b1;
                            tx_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    clk_oe_q   <= 1'b0;
                    data_oe_q  <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready    = tx_ready_q;
    assign bus.busy        = busy_q;
    assign bus.ps2_clk_oe  = clk_oe_q;
    assign bus.ps2_data_oe = data_oe_q;
    assign bus.tx_done     = done_q;
    assign bus.tx_error    = error_q;
    assign bus.err_code    = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: open-drain line model, a simple PS/2 device, table of sends.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH   = 200;
    localparam int REQ_C = 50;
    localparam int TMO   = 3000;
    localparam int HALF  = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;

    always #10 clock = ~clock;

    ps2_host_tx_if bus ();

    assign bus.ps2_clk_in  = ~(bus.ps2_clk_oe | dev_clk_low);
    assign bus.ps2_data_in = ~(bus.ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .REQ_CYCLES     (REQ_C),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    logic [1:0] err_seen = '0;
    logic pulse_prev = 1'b0;
    logic ready_after = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (pulse_prev) ready_after = bus.tx_ready;
        pulse_prev = bus.tx_done | bus.tx_error;
        if (bus.tx_done) done_cnt++;
        if (bus.tx_error) begin
            err_cnt++;
            err_seen = bus.err_code;
            err_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Offer one byte, optionally poke a second byte mid-inhibit, and measure the request phases.
    task automatic send(input logic [7:0] d, input bit glitch,
                        output int n_inh, output int n_req, output int c0);
        @(negedge clock);
        bus.tx_data = d;
        bus.tx_valid = 1'b1;
        @(negedge clock);
        bus.tx_valid = 1'b0;
        n_inh = 0;
        while (bus.ps2_clk_oe && !bus.ps2_data_oe && n_inh < INH + 100) begin
            n_inh++;
            if (glitch && n_inh == 10) begin
                bus.tx_data = 8'h55;
                bus.tx_valid = 1'b1;
            end
            if (glitch && n_inh == 11) bus.tx_valid = 1'b0;
            @(negedge clock);
        end
        n_req = 0;
        while (bus.ps2_clk_oe && bus.ps2_data_oe && n_req < REQ_C + 100) begin
            n_req++;
            @(negedge clock);
        end
        c0 = cyc;
    endtask

    // Device clocks npulses bits, reading the data line at each rising edge, then optionally the ACK pulse.
    task automatic device(input int npulses, input bit do_ack, input bit ack_low,
                          output logic [9:0] bits);
        bits = '0;
        repeat (HALF) @(negedge clock);
        for (int i = 0; i < npulses; i++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            bits[i] = bus.ps2_data_in;
            dev_clk_low = 1'b0;
            repeat (HALF) @(negedge clock);
        end
        if (do_ack) begin
            if (ack_low) dev_data_low = 1'b1;
            repeat (5) @(negedge clock);
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk_low = 1'b0;
            repeat (5) @(negedge clock);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic wait_end(input int limit);
        for (int k = 0; k < limit; k++) begin
            if (done_cnt + err_cnt > 0) break;
            @(negedge clock);
        end
        check("completion_seen", 32'(done_cnt + err_cnt > 0), 32'd1);
        repeat (3) @(negedge clock);
    endtask

    typedef struct {
        logic [7:0] data;
        bit         ack_low;
        logic [9:0] exp_frame;
        int         exp_done;
        int         exp_err;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int ni, nr, c0;
        logic [9:0] bits;

        // Frame as read by the device: {stop, odd parity, data}, bit 0 first on the wire.
        vecs[0] = '{8'hED, 1'b1, 10'h3ED, 1, 0, 2'b00};
        vecs[1] = '{8'h01, 1'b1, 10'h201, 1, 0, 2'b00};
        vecs[2] = '{8'hFF, 1'b0, 10'h3FF, 0, 1, 2'b01};
        vecs[3] = '{8'h00, 1'b1, 10'h300, 1, 0, 2'b01};

        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_clk_oe", 32'(bus.ps2_clk_oe), 32'd0);
        check("reset_data_oe", 32'(bus.ps2_data_oe), 32'd0);
        check("reset_err_code", 32'(bus.err_code), 32'd0);

        for (int v = 0; v < 4; v++) begin
            done_cnt = 0;
            err_cnt = 0;
            ready_after = 1'b0;
            send(vecs[v].data, 1'b0, ni, nr, c0);
            check($sformatf("v%0d_inhibit_len", v), 32'(ni), 32'(INH));
            check($sformatf("v%0d_req_len", v), 32'(nr), 32'(REQ_C));
            device(10, 1'b1, vecs[v].ack_low, bits);
            wait_end(1000);
            check($sformatf("v%0d_frame", v), 32'(bits), 32'(vecs[v].exp_frame));
            check($sformatf("v%0d_done_cycles", v), 32'(done_cnt), 32'(vecs[v].exp_done));
            check($sformatf("v%0d_error_cycles", v), 32'(err_cnt), 32'(vecs[v].exp_err));
            check($sformatf("v%0d_err_code", v), 32'(bus.err_code), 32'(vecs[v].exp_code));
            check($sformatf("v%0d_ready_after_pulse", v), 32'(ready_after), 32'd1);
            check($sformatf("v%0d_lines_released", v),
                  32'({bus.ps2_clk_oe, bus.ps2_data_oe, bus.busy}), 32'd0);
        end

        // Device never clocks: timeout exactly TMO cycles after SEND entry.
        done_cnt = 0;
        err_cnt = 0;
        send(CMD_SET_LEDS, 1'b0, ni, nr, c0);
        wait_end(TMO + 200);
        check("tmo_error_cycles", 32'(err_cnt), 32'd1);
        check("tmo_err_code", 32'(err_seen), 32'(ERR_TIMEOUT));
        check("tmo_latency", 32'(err_cyc - c0), 32'(TMO));
        check("tmo_no_done", 32'(done_cnt), 32'd0);
        check("tmo_lines_released", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);

        // Reset while the device holds clock low on fall 5 (bit 4 of 0xED is 0, so data is driven).
        send(CMD_SET_LEDS, 1'b0, ni, nr, c0);
        device(4, 1'b0, 1'b0, bits);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        check("rst_pre_data_oe", 32'(bus.ps2_data_oe), 32'd1);
        done_cnt = 0;
        err_cnt = 0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_lines", 32'({bus.ps2_clk_oe, bus.ps2_data_oe}), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_tx_ready", 32'(bus.tx_ready), 32'd1);
        check("rst_err_code", 32'(bus.err_code), 32'd0);
        dev_clk_low = 1'b0;
        repeat (10) @(negedge clock);
        check("rst_no_pulses", 32'(done_cnt + err_cnt), 32'd0);

        // Normal 0xFF send after the aborted transaction.
        done_cnt = 0;
        err_cnt = 0;
        send(CMD_RESET, 1'b0, ni, nr, c0);
        device(10, 1'b1, 1'b1, bits);
        wait_end(1000);
        check("ff_frame", 32'(bits), 32'h3FF);
        check("ff_done_cycles", 32'(done_cnt), 32'd1);
        check("ff_no_error", 32'(err_cnt), 32'd0);

        // 0x55 offered during inhibit must be ignored.
        done_cnt = 0;
        err_cnt = 0;
        send(CMD_SET_LEDS, 1'b1, ni, nr, c0);
        check("busy_inhibit_len", 32'(ni), 32'(INH));
        device(10, 1'b1, 1'b1, bits);
        wait_end(1000);
        check("busy_frame", 32'(bits), 32'h3ED);
        check("busy_done_cycles", 32'(done_cnt), 32'd1);
        repeat (20) @(negedge clock);
        check("busy_no_second_tx", 32'({bus.ps2_clk_oe, bus.busy, bus.tx_ready}), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
